// File: rtl/m_axi_rd_engine.sv
// AXI4 read-master DMA engine: splits a byte-range command into INCR bursts and streams the beats out.
// Define M_AXI_RD_4K_SPLIT_EN to keep every burst inside one 4KB page.
module m_axi_rd_engine #(
    parameter int C_DATA_WIDTH      = 128,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_AXI_BURST       = 16,
    parameter int C_FIFO_DEPTH      = 256,
    parameter int C_MAX_OUTSTANDING = 8
) (
    input  logic                    I_clk,
    input  logic                    I_rst,
    input  logic                    I_cmd_valid,
    output logic                    O_cmd_ready,
    input  logic [C_ADDR_WIDTH-1:0] I_cmd_addr,
    input  logic [31:0]             I_cmd_bytes,
    output logic                    O_done,
    output logic                    O_err,
    output logic [C_ADDR_WIDTH-1:0] O_araddr,
    output logic [7:0]              O_arlen,
    output logic                    O_arvalid,
    input  logic                    I_arready,
    output logic [2:0]              O_arsize,
    output logic [1:0]              O_arburst,
    output logic [3:0]              O_arcache,
    output logic [2:0]              O_arprot,
    output logic [3:0]              O_arid,
    output logic                    O_arlock,
    input  logic [C_DATA_WIDTH-1:0] I_rdata,
    input  logic                    I_rvalid,
    input  logic                    I_rlast,
    input  logic [1:0]              I_rresp,
    output logic                    O_rready,
    output logic [C_DATA_WIDTH-1:0] O_dout,
    output logic                    O_dout_valid,
    output logic                    O_dout_last,
    input  logic                    I_dout_ready,
    output logic [2:0]              dbg_state
);
    localparam int BPB    = C_DATA_WIDTH / 8;
    localparam int LG_BPB = $clog2(BPB);
    localparam int FAW    = $clog2(C_FIFO_DEPTH);
    localparam int RW     = FAW + 1;
    localparam int OW     = $clog2(C_MAX_OUTSTANDING + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]              state;
    logic [C_ADDR_WIDTH-1:0] addr;
    logic [31:0]             remaining;
    logic [31:0]             total_beats;
    logic [31:0]             pop_cnt;
    logic [8:0]              len_beats;
    logic [RW-1:0]           reserved;
    logic [OW-1:0]           outstanding;
    logic                    arvalid;
    logic                    err;
    logic                    done;

    logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [FAW-1:0]          wptr;
    logic [FAW-1:0]          rptr;
    logic [RW-1:0]           count;

    logic        cmd_fire, ar_fire, r_fire, rlast_fire, pop, credit_ok;
    logic [31:0] cmd_beats;
    logic [31:0] calc_len;
    logic [RW-1:0] res_add;

    // Every channel uses valid/ready: a transfer happens on the clock edge where both are high;
    // a raised valid and its payload stay unchanged until that edge.
    assign cmd_fire   = I_cmd_valid && (state == S_IDLE);
    assign ar_fire    = arvalid && I_arready;
    assign r_fire     = I_rvalid && O_rready;
    assign rlast_fire = r_fire && I_rlast;
    assign pop        = O_dout_valid && I_dout_ready;

    assign cmd_beats = (I_cmd_bytes >> LG_BPB) + {31'd0, |I_cmd_bytes[LG_BPB-1:0]};

`ifdef M_AXI_RD_4K_SPLIT_EN
    logic [31:0] page_beats;
`endif

    always_comb begin
        calc_len = (remaining < 32'(C_AXI_BURST)) ? remaining : 32'(C_AXI_BURST);
`ifdef M_AXI_RD_4K_SPLIT_EN
        page_beats = (32'd4096 - {20'd0, addr[11:0]}) >> LG_BPB;
        if (page_beats < calc_len) calc_len = page_beats;
`endif
    end

    // reserved counts beats issued but not yet popped, so it already covers FIFO contents
    assign credit_ok = ((32'(C_FIFO_DEPTH) - 32'(reserved)) >= 32'(len_beats)) &&
                       (32'(outstanding) < 32'(C_MAX_OUTSTANDING));
    assign res_add   = ar_fire ? RW'(len_beats) : '0;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state       <= S_IDLE;
            addr        <= '0;
            remaining   <= '0;
            total_beats <= '0;
            len_beats   <= '0;
            arvalid     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (I_cmd_valid) begin
                    addr        <= I_cmd_addr & ~C_ADDR_WIDTH'(BPB - 1);
                    remaining   <= cmd_beats;
                    total_beats <= cmd_beats;
                    state       <= (cmd_beats == 32'd0) ? S_DONE : S_CALC;
                end
                S_CALC: begin
                    len_beats <= 9'(calc_len);
                    state     <= S_ADDR;
                end
                S_ADDR: begin
                    if (!arvalid) begin
                        if (credit_ok) arvalid <= 1'b1;
                    end else if (I_arready) begin
                        arvalid   <= 1'b0;
                        addr      <= addr + (C_ADDR_WIDTH'(len_beats) << LG_BPB);
                        remaining <= remaining - 32'(len_beats);
                        state     <= (remaining == 32'(len_beats)) ? S_WAIT : S_CALC;
                    end
                end
                S_WAIT: if (outstanding == '0 && pop_cnt == total_beats) state <= S_DONE;
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            reserved    <= '0;
            outstanding <= '0;
            pop_cnt     <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done     <= (state == S_DONE);
            reserved <= reserved + res_add - {{FAW{1'b0}}, pop};
            case ({ar_fire, rlast_fire})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (cmd_fire) pop_cnt <= '0;
            else if (pop) pop_cnt <= pop_cnt + 32'd1;
            if (cmd_fire) err <= 1'b0;
            else if (r_fire && I_rresp != 2'b00) err <= 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (r_fire) wptr <= wptr + FAW'(1);
            if (pop) rptr <= rptr + FAW'(1);
            count <= count + {{FAW{1'b0}}, r_fire} - {{FAW{1'b0}}, pop};
        end
    end

    always_ff @(posedge I_clk) begin
        if (r_fire) mem[wptr] <= I_rdata;
    end

    assign O_cmd_ready  = (state == S_IDLE);
    assign O_rready     = (state != S_IDLE);
    assign O_arvalid    = arvalid;
    assign O_araddr     = addr;
    assign O_arlen      = 8'(len_beats - 9'd1);
    assign O_arsize     = 3'(LG_BPB);
    assign O_arburst    = 2'b01;
    assign O_arcache    = 4'b0010;
    assign O_arprot     = 3'b010;
    assign O_arid       = 4'd0;
    assign O_arlock     = 1'b0;
    assign O_dout       = mem[rptr];
    assign O_dout_valid = (count != '0);
    assign O_dout_last  = O_dout_valid && (pop_cnt == total_beats - 32'd1);
    assign O_done       = done;
    assign O_err        = err;
    assign dbg_state    = state;
endmodule

// File: tb/tb_m_axi_rd_engine.sv
// Directed bench for m_axi_rd_engine: AXI read slave model, stream sink log and per-scenario checks.
module tb_m_axi_rd_engine;
    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [31:0]  cmd_addr, cmd_bytes;
    logic         done, err;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         arvalid, arready;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst;
    logic [3:0]   arcache, arid;
    logic         arlock;
    logic [127:0] rdata;
    logic         rvalid, rlast;
    logic [1:0]   rresp;
    logic         rready;
    logic [127:0] dout;
    logic         dout_valid, dout_last, dout_ready;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int r_count = 0;
    int err_at = -1;
    bit rready_drop = 0;

    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    logic         got_last_q[$];
    logic [31:0]  ar_addr_q[$];
    logic [7:0]   ar_len_q[$];
    logic [31:0]  pend_addr_q[$];
    logic [7:0]   pend_len_q[$];

    m_axi_rd_engine #(
        .C_DATA_WIDTH(128), .C_ADDR_WIDTH(32), .C_AXI_BURST(16),
        .C_FIFO_DEPTH(32), .C_MAX_OUTSTANDING(8)
    ) dut (
        .I_clk(clk), .I_rst(rst),
        .I_cmd_valid(cmd_valid), .O_cmd_ready(cmd_ready),
        .I_cmd_addr(cmd_addr), .I_cmd_bytes(cmd_bytes),
        .O_done(done), .O_err(err),
        .O_araddr(araddr), .O_arlen(arlen), .O_arvalid(arvalid), .I_arready(arready),
        .O_arsize(arsize), .O_arburst(arburst), .O_arcache(arcache),
        .O_arprot(arprot), .O_arid(arid), .O_arlock(arlock),
        .I_rdata(rdata), .I_rvalid(rvalid), .I_rlast(rlast), .I_rresp(rresp),
        .O_rready(rready),
        .O_dout(dout), .O_dout_valid(dout_valid), .O_dout_last(dout_last),
        .I_dout_ready(dout_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1);
    end

    // Memory content seen by the slave: a fixed function of the beat's byte address.
    function automatic logic [127:0] beat_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0003, a ^ 32'h5A5A_0002, a ^ 32'h0F0F_0001, a};
    endfunction

    // ---------------- AXI read slave ----------------
    initial begin
        int beat;
        bit ar_f, r_f, rst_s;
        logic [31:0] a;
        logic [7:0] l;
        beat = 0;
        rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            ar_f = arvalid && arready;
            r_f = rvalid && rready;
            rst_s = rst;
            a = araddr;
            l = arlen;
            @(posedge clk); #1;
            if (rst_s) begin
                pend_addr_q.delete();
                pend_len_q.delete();
                beat = 0;
            end else begin
                if (r_f) begin
                    r_count++;
                    if (beat == int'(pend_len_q[0])) begin
                        void'(pend_addr_q.pop_front());
                        void'(pend_len_q.pop_front());
                        beat = 0;
                    end else beat++;
                end
                if (ar_f) begin
                    pend_addr_q.push_back(a);
                    pend_len_q.push_back(l);
                end
            end
            if (pend_addr_q.size() > 0) begin
                rvalid = 1'b1;
                rdata = beat_word(pend_addr_q[0] + 32'(beat * 16));
                rlast = (beat == int'(pend_len_q[0]));
                rresp = (r_count == err_at) ? 2'd2 : 2'd0;
            end else begin
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dout_valid && dout_ready) begin
                    got_q.push_back(dout);
                    got_last_q.push_back(dout_last);
                end
                if (arvalid && arready) begin
                    ar_addr_q.push_back(araddr);
                    ar_len_q.push_back(arlen);
                end
                if (done) done_cnt++;
                if (!cmd_ready && !rready) rready_drop = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [31:0] b);
        int nb;
        got_q.delete(); got_last_q.delete();
        ar_addr_q.delete(); ar_len_q.delete();
        exp_q.delete();
        done_cnt = 0;
        rready_drop = 0;
        nb = int'((64'(b) + 64'd15) / 64'd16);
        for (int i = 0; i < nb; i++) exp_q.push_back(beat_word((a & 32'hFFFF_FFF0) + 32'(i * 16)));
        cmd_addr = a; cmd_bytes = b; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b expected 0", rready); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dout_valid: got %b expected 0", dout_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        checks++; if (arsize !== 3'd4 || arburst !== 2'b01 || arcache !== 4'b0010 || arprot !== 3'b010 || arid !== 4'd0 || arlock !== 1'b0) begin
            errors++; $display("FAIL rst_ar_consts: got size %0d burst %b cache %b prot %b id %0d lock %b expected 4 01 0010 010 0 0",
                               arsize, arburst, arcache, arprot, arid, arlock);
        end
    endtask

    task automatic test_two_bursts();
        bit ok;
        int n_last, last_pos;
        logic [31:0] ea [2];
        ea = '{32'h1000, 32'h1100};
        start_cmd(32'h1000, 32'd512);
        wait_done(1000, ok);
        cycles(3);
        checks++; if (!ok) begin errors++; $display("FAIL two_done_seen: got 0 expected 1"); end
        checks++; if (ar_addr_q.size() != 2) begin errors++; $display("FAIL two_ar_count: got %0d expected 2", ar_addr_q.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= ar_addr_q.size() || ar_addr_q[i] !== ea[i] || ar_len_q[i] !== 8'd15) begin
                errors++; $display("FAIL two_ar[%0d]: got %h/%0d expected %h/15", i,
                                   (i < ar_addr_q.size()) ? ar_addr_q[i] : 32'hx, (i < ar_len_q.size()) ? ar_len_q[i] : 8'hx, ea[i]);
            end
        end
        checks++; if (got_q.size() != 32) begin errors++; $display("FAIL two_beats: got %0d expected 32", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL two_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
            end
        end
        n_last = 0; last_pos = -1;
        foreach (got_last_q[i]) if (got_last_q[i]) begin n_last++; last_pos = i; end
        checks++; if (n_last != 1 || last_pos != 31) begin errors++; $display("FAIL two_last: got count %0d pos %0d expected 1 at 31", n_last, last_pos); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL two_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_partial();
        bit ok;
        int n_last, last_pos;
        start_cmd(32'h2007, 32'd40);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL part_done_seen: got 0 expected 1"); end
        checks++;
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 32'h2000 || ar_len_q[0] !== 8'd2) begin
            errors++; $display("FAIL part_ar: got %0d ARs first %h/%0d expected 1 AR 00002000/2", ar_addr_q.size(),
                               (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'hx, (ar_len_q.size() > 0) ? ar_len_q[0] : 8'hx);
        end
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL part_beats: got %0d expected 3", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL part_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
            end
        end
        n_last = 0; last_pos = -1;
        foreach (got_last_q[i]) if (got_last_q[i]) begin n_last++; last_pos = i; end
        checks++; if (n_last != 1 || last_pos != 2) begin errors++; $display("FAIL part_last: got count %0d pos %0d expected 1 at 2", n_last, last_pos); end
    endtask

`ifdef M_AXI_RD_4K_SPLIT_EN
    task automatic test_4k_split();
        bit ok;
        int n_last, last_pos;
        logic [31:0] ea [3];
        logic [7:0]  el [3];
        ea = '{32'h0F80, 32'h1000, 32'h1100};
        el = '{8'd7, 8'd15, 8'd7};
        start_cmd(32'h0F80, 32'd512);
        wait_done(1000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL k4_done_seen: got 0 expected 1"); end
        checks++; if (ar_addr_q.size() != 3) begin errors++; $display("FAIL k4_ar_count: got %0d expected 3", ar_addr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= ar_addr_q.size() || ar_addr_q[i] !== ea[i] || ar_len_q[i] !== el[i]) begin
                errors++; $display("FAIL k4_ar[%0d]: got %h/%0d expected %h/%0d", i,
                                   (i < ar_addr_q.size()) ? ar_addr_q[i] : 32'hx, (i < ar_len_q.size()) ? ar_len_q[i] : 8'hx, ea[i], el[i]);
            end
        end
        checks++; if (got_q.size() != 32) begin errors++; $display("FAIL k4_beats: got %0d expected 32", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL k4_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
            end
        end
        n_last = 0; last_pos = -1;
        foreach (got_last_q[i]) if (got_last_q[i]) begin n_last++; last_pos = i; end
        checks++; if (n_last != 1 || last_pos != 31) begin errors++; $display("FAIL k4_last: got count %0d pos %0d expected 1 at 31", n_last, last_pos); end
    endtask
`endif

    task automatic test_backpressure();
        bit ok;
        int n_last, last_pos;
        dout_ready = 1'b0;
        start_cmd(32'h0000_0000, 32'd4096);
        cycles(200);
        checks++; if (ar_addr_q.size() != 2) begin errors++; $display("FAIL bp_ar_held: got %0d ARs expected 2", ar_addr_q.size()); end
        checks++; if (dout_valid !== 1'b1 || dout !== beat_word(32'h0)) begin
            errors++; $display("FAIL bp_head: got valid %b data %h expected 1 %h", dout_valid, dout, beat_word(32'h0));
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_no_pop: got %0d expected 0", got_q.size()); end
        dout_ready = 1'b1;
        wait_done(4000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done_seen: got 0 expected 1"); end
        checks++; if (rready_drop) begin errors++; $display("FAIL bp_rready: got rready 0 while busy expected always 1"); end
        checks++; if (ar_addr_q.size() != 16) begin errors++; $display("FAIL bp_ar_count: got %0d expected 16", ar_addr_q.size()); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= ar_addr_q.size() || ar_addr_q[i] !== 32'(i * 256) || ar_len_q[i] !== 8'd15) begin
                errors++; $display("FAIL bp_ar[%0d]: got %h/%0d expected %h/15", i,
                                   (i < ar_addr_q.size()) ? ar_addr_q[i] : 32'hx, (i < ar_len_q.size()) ? ar_len_q[i] : 8'hx, 32'(i * 256));
            end
        end
        checks++; if (got_q.size() != 256) begin errors++; $display("FAIL bp_beats: got %0d expected 256", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
            end
        end
        n_last = 0; last_pos = -1;
        foreach (got_last_q[i]) if (got_last_q[i]) begin n_last++; last_pos = i; end
        checks++; if (n_last != 1 || last_pos != 255) begin errors++; $display("FAIL bp_last: got count %0d pos %0d expected 1 at 255", n_last, last_pos); end
    endtask

    task automatic test_rresp_err();
        bit ok;
        err_at = r_count + 4;
        start_cmd(32'h3000, 32'd128);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", err); end
        wait_done(400, ok);
        err_at = -1;
        cycles(2);
        checks++; if (!ok) begin errors++; $display("FAIL err_done_seen: got 0 expected 1"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        checks++; if (got_q.size() != 8) begin errors++; $display("FAIL err_beats: got %0d expected 8", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL err_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_bytes();
        start_cmd(32'h4000, 32'd0);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err_clear: got %b expected 0", err); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_c1: got %b expected 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_c2: got %b expected 1", done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_c3: got %b expected 0", done); end
        @(posedge clk); #1;
        checks++; if (ar_addr_q.size() != 0) begin errors++; $display("FAIL zero_no_ar: got %0d expected 0", ar_addr_q.size()); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero_no_beats: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        dout_ready = 1'b0;
        start_cmd(32'h0000_0000, 32'd4096);
        cycles(40);
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", dout_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rmid_arvalid: got %b expected 0", arvalid); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_dout_valid: got %b expected 0", dout_valid); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rmid_rready: got %b expected 0", rready); end
        dout_ready = 1'b1;
        start_cmd(32'h2000, 32'd40);
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_done_seen: got 0 expected 1"); end
        checks++; if (got_q.size() != 3) begin errors++; $display("FAIL rmid_beats: got %0d expected 3", got_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rmid_data[%0d]: got %h expected %h", i, (i < got_q.size()) ? got_q[i] : 128'hx, exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_bytes = '0;
        arready = 1'b1; dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_two_bursts();
        test_partial();
`ifdef M_AXI_RD_4K_SPLIT_EN
        test_4k_split();
`endif
        test_backpressure();
        test_rresp_err();
        test_zero_bytes();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
